// File: rtl/sc_pwm_ramp_controller_if.sv
// Command-side and counter-side signals of one sc_pwm_ramp_controller channel.
// duty_load_in is a one-cycle valid with no ready: the controller always accepts it on the next edge.
interface sc_pwm_ramp_controller_if #(
  parameter int N = 8
);
  logic         ctrl_run_in;
  logic         ctrl_brake_in;
  logic [N-1:0] duty_target_in;
  logic         duty_load_in;
  logic         cnt_endcount_outlow_in;
  logic         cnt_flag_outlow_in;
  logic         cnt_enable_inlow_out;
  logic         cnt_clear_inlow_out;
  logic [N-1:0] cnt_flagcomp_out;
  logic         pwm_out;
  logic         period_done_out;
  logic         at_target_out;
  logic         busy_out;
  logic [1:0]   state_dbg;

  modport master (
    output ctrl_run_in, ctrl_brake_in, duty_target_in, duty_load_in,
           cnt_endcount_outlow_in, cnt_flag_outlow_in,
    input  cnt_enable_inlow_out, cnt_clear_inlow_out, cnt_flagcomp_out,
           pwm_out, period_done_out, at_target_out, busy_out, state_dbg
  );

  modport slave (
    input  ctrl_run_in, ctrl_brake_in, duty_target_in, duty_load_in,
           cnt_endcount_outlow_in, cnt_flag_outlow_in,
    output cnt_enable_inlow_out, cnt_clear_inlow_out, cnt_flagcomp_out,
           pwm_out, period_done_out, at_target_out, busy_out, state_dbg
  );
endinterface

// File: rtl/sc_pwm_ramp_controller.sv
// Sequencer for one SC_COUNTER_PWM channel: period-aligned duty updates and glitch-free PWM.
// Define SC_PWM_RAMP_EN to build the soft-start duty ramp.
module sc_pwm_ramp_controller #(
  parameter int N         = 8,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_DIV  = 4
) (
  input logic SC_COUNTER_PWM_CLOCK,
  input logic SC_COUNTER_PWM_RESET_InHigh,
  sc_pwm_ramp_controller_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  if (RAMP_STEP < 1 || RAMP_STEP > (1 << N) - 1 || RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_cfg_check
    $error("sc_pwm_ramp_controller: RAMP_STEP or RAMP_DIV out of range");
  end

  state_t       state_q, state_d;
  logic [N-1:0] duty_tgt_q, duty_tgt_d;
  logic [N-1:0] duty_cur_q, duty_cur_d;
  logic         pwm_q, pwm_d;
  logic         period_done_q, period_done_d;
  logic         wrap, cmp_hit;
  logic [N-1:0] start_duty, next_duty;

  assign wrap    = ~bus.cnt_endcount_outlow_in;
  assign cmp_hit = ~bus.cnt_flag_outlow_in;

`ifdef SC_PWM_RAMP_EN
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
  localparam logic [N:0] STEP_X    = (N+1)'(RAMP_STEP);

  logic [7:0]   ramp_cnt_q, ramp_cnt_d, ramp_cnt_next;
  logic [N:0]   cur_x, tgt_x;
  logic [N-1:0] ramped;

  // One extra bit so the step can neither wrap past 0 nor past 2^N-1.
  always_comb begin
    cur_x  = {1'b0, duty_cur_q};
    tgt_x  = {1'b0, duty_tgt_q};
    ramped = duty_cur_q;
    if (cur_x < tgt_x) begin
      ramped = (cur_x + STEP_X >= tgt_x) ? duty_tgt_q : N'(cur_x + STEP_X);
    end else if (cur_x > tgt_x) begin
      ramped = (cur_x <= tgt_x + STEP_X) ? duty_tgt_q : N'(cur_x - STEP_X);
    end
  end

  assign start_duty    = '0;
  assign next_duty     = (ramp_cnt_q == RAMP_LAST) ? ramped : duty_cur_q;
  assign ramp_cnt_next = (ramp_cnt_q == RAMP_LAST) ? 8'd0 : ramp_cnt_q + 8'd1;
`else
  assign start_duty = duty_tgt_q;
  assign next_duty  = duty_tgt_q;
`endif

  always_comb begin
    state_d       = state_q;
    duty_cur_d    = duty_cur_q;
    pwm_d         = pwm_q;
    period_done_d = 1'b0;
    duty_tgt_d    = bus.duty_load_in ? bus.duty_target_in : duty_tgt_q;
`ifdef SC_PWM_RAMP_EN
    ramp_cnt_d    = ramp_cnt_q;
`endif
    if (bus.ctrl_brake_in) begin
      state_d = ST_IDLE;
      pwm_d   = 1'b0;
`ifdef SC_PWM_RAMP_EN
      ramp_cnt_d = 8'd0;
      duty_cur_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          pwm_d = 1'b0;
          if (bus.ctrl_run_in) begin
            state_d    = ST_RUN;
            duty_cur_d = start_duty;
            pwm_d      = (start_duty != '0);
`ifdef SC_PWM_RAMP_EN
            ramp_cnt_d = 8'd0;
`endif
          end
        end
        ST_RUN, ST_STOPPING: begin
          state_d = bus.ctrl_run_in ? ST_RUN : ST_STOPPING;
          if (cmp_hit) pwm_d = 1'b0;
          // A wrap with run low ends the channel; the set below wins over a coincident compare clear.
          if (wrap) begin
            period_done_d = 1'b1;
            if (bus.ctrl_run_in) begin
              duty_cur_d = next_duty;
              pwm_d      = (next_duty != '0);
`ifdef SC_PWM_RAMP_EN
              ramp_cnt_d = ramp_cnt_next;
`endif
            end else begin
              state_d = ST_IDLE;
              pwm_d   = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_COUNTER_PWM_CLOCK or posedge SC_COUNTER_PWM_RESET_InHigh) begin
    if (SC_COUNTER_PWM_RESET_InHigh) begin
      state_q       <= ST_IDLE;
      duty_tgt_q    <= '0;
      duty_cur_q    <= '0;
      pwm_q         <= 1'b0;
      period_done_q <= 1'b0;
`ifdef SC_PWM_RAMP_EN
      ramp_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      duty_tgt_q    <= duty_tgt_d;
      duty_cur_q    <= duty_cur_d;
      pwm_q         <= pwm_d;
      period_done_q <= period_done_d;
`ifdef SC_PWM_RAMP_EN
      ramp_cnt_q    <= ramp_cnt_d;
`endif
    end
  end

  assign bus.cnt_clear_inlow_out  = (state_q != ST_IDLE);
  assign bus.cnt_enable_inlow_out = (state_q == ST_IDLE);
  assign bus.cnt_flagcomp_out     = (duty_cur_q == '0) ? '0 : duty_cur_q - N'(1);
  assign bus.pwm_out              = pwm_q;
  assign bus.period_done_out      = period_done_q;
  assign bus.at_target_out        = (duty_cur_q == duty_tgt_q);
  assign bus.busy_out             = (state_q != ST_IDLE);
  assign bus.state_dbg            = state_q;
endmodule

// File: tb/tb_sc_pwm_ramp_controller.sv
// Bench for sc_pwm_ramp_controller with a counter model, a per-period duty model and a period monitor.
// Builds the ramp expectations when SC_PWM_RAMP_EN is defined.
module tb_sc_pwm_ramp_controller;
  localparam int N         = 4;
  localparam int RAMP_STEP = 2;
  localparam int RAMP_DIV  = 2;
  localparam int PERIOD    = 1 << N;
  localparam int DMAX      = PERIOD - 1;
`ifdef SC_PWM_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_pwm_ramp_controller_if #(.N(N)) bus ();

  sc_pwm_ramp_controller #(.N(N), .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV)) dut (
    .SC_COUNTER_PWM_CLOCK        (clk),
    .SC_COUNTER_PWM_RESET_InHigh (rst),
    .bus                         (bus)
  );

  // SC_COUNTER_PWM stand-in: synchronous active-low clear, active-low enable, shared async reset
  logic [N-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (!bus.cnt_clear_inlow_out) cnt <= '0;
    else if (!bus.cnt_enable_inlow_out) cnt <= cnt + 1'b1;
  end
  assign bus.cnt_endcount_outlow_in = (cnt != N'(DMAX));
  assign bus.cnt_flag_outlow_in     = (cnt != bus.cnt_flagcomp_out);

  // scoreboard
  logic [N-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // reference model: duty per period from the target, ramp cadence and run/brake history
  int m_tgt  = 0;
  int m_cur  = 0;
  int m_ramp = 0;
  bit m_busy = 1'b0;

  task automatic model_period_start(input bit from_idle);
    if (from_idle) begin
      m_cur  = RAMP_ON ? 0 : m_tgt;
      m_ramp = 0;
    end else if (!RAMP_ON) begin
      m_cur = m_tgt;
    end else if (m_ramp == RAMP_DIV - 1) begin
      m_ramp = 0;
      if (m_cur < m_tgt) m_cur = (m_cur + RAMP_STEP > m_tgt) ? m_tgt : m_cur + RAMP_STEP;
      else if (m_cur > m_tgt) m_cur = (m_cur - RAMP_STEP < m_tgt) ? m_tgt : m_cur - RAMP_STEP;
    end else begin
      m_ramp++;
    end
    m_busy = 1'b1;
    exp_q.push_back(N'(m_cur));
  endtask

  // monitor: measure each period's high time, length and contiguity
  int hi_cnt  = 0;
  int len_cnt = 0;
  bit gap     = 1'b0;
  logic [N-1:0] exp_duty;

  always @(negedge clk) begin
    if (rst) begin
      hi_cnt = 0; len_cnt = 0; gap = 1'b0;
    end else begin
      if (bus.period_done_out) begin
        check("exp_q_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_duty = exp_q.pop_front();
          check("period_high_clocks", hi_cnt, int'(exp_duty));
          check("period_length", len_cnt, PERIOD);
          check("period_contiguous", int'(gap), 0);
        end
        hi_cnt = 0; len_cnt = 0; gap = 1'b0;
      end
      if (!bus.busy_out) begin
        hi_cnt = 0; len_cnt = 0; gap = 1'b0;
      end else begin
        if (bus.pwm_out) begin
          if (hi_cnt != len_cnt) gap = 1'b1;
          hi_cnt++;
        end
        len_cnt++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pwm"}, bus.pwm_out, 0);
    check({tag, "_clear_n"}, bus.cnt_clear_inlow_out, 0);
    check({tag, "_enable_n"}, bus.cnt_enable_inlow_out, 1);
    check({tag, "_flagcomp"}, bus.cnt_flagcomp_out, 0);
    check({tag, "_busy"}, bus.busy_out, 0);
    check({tag, "_at_target"}, bus.at_target_out, 1);
    check({tag, "_period_done"}, bus.period_done_out, 0);
  endtask

  task automatic idle_cycles(input int n, input int load_val);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && load_val >= 0) begin
        bus.duty_target_in = N'(load_val);
        bus.duty_load_in   = 1'b1;
      end
      tick();
      bus.duty_load_in = 1'b0;
      if (i == 0 && load_val >= 0) m_tgt = load_val;
      check("idle_busy", bus.busy_out, 0);
      check("idle_clear_n", bus.cnt_clear_inlow_out, 0);
      check("idle_enable_n", bus.cnt_enable_inlow_out, 1);
      check("idle_pwm", bus.pwm_out, 0);
      check("idle_cnt_held", int'(cnt), 0);
      check("idle_at_target", bus.at_target_out, int'(m_cur == m_tgt));
    end
  endtask

  task automatic start_run();
    bus.ctrl_run_in = 1'b1;
    tick();
    model_period_start(1'b1);
    check("start_busy", bus.busy_out, 1);
    check("start_clear_n", bus.cnt_clear_inlow_out, 1);
    check("start_enable_n", bus.cnt_enable_inlow_out, 0);
    check("start_cnt_zero", int'(cnt), 0);
    check("start_pwm", bus.pwm_out, int'(m_cur != 0));
  endtask

  // one period from count 0; -1 disables an event, resume_at only matters after stop_at
  task automatic do_period(input int load_at, input int load_val, input int stop_at,
                           input int resume_at, input int brake_at);
    bit ended;
    ended = 1'b0;
    for (int c = 0; c < PERIOD && !ended; c++) begin
      if (c == load_at) begin
        bus.duty_target_in = N'(load_val);
        bus.duty_load_in   = 1'b1;
      end
      if (c == stop_at) bus.ctrl_run_in = 1'b0;
      if (c == resume_at) bus.ctrl_run_in = 1'b1;
      if (c == brake_at) bus.ctrl_brake_in = 1'b1;
      tick();
      bus.duty_load_in = 1'b0;
      if (c == brake_at) begin
        bus.ctrl_brake_in = 1'b0;
        bus.ctrl_run_in   = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        if (RAMP_ON) m_cur = 0;
        m_ramp = 0;
        m_busy = 1'b0;
        check("brake_pwm", bus.pwm_out, 0);
        check("brake_clear_n", bus.cnt_clear_inlow_out, 0);
        check("brake_no_done", bus.period_done_out, 0);
        ended = 1'b1;
      end else if (c == PERIOD - 1) begin
        if (bus.ctrl_run_in) model_period_start(1'b0);
        else m_busy = 1'b0;
      end
      if (c == load_at) m_tgt = load_val;
      check("cycle_busy", bus.busy_out, int'(m_busy));
      check("cycle_at_target", bus.at_target_out, int'(m_cur == m_tgt));
    end
  endtask

  task automatic reset_mid(input int at_count);
    for (int c = 0; c < at_count; c++) tick();
    check("pre_reset_pwm", bus.pwm_out, int'(m_cur > at_count));
    #1 rst = 1'b1;
    exp_q.delete();
    m_tgt = 0; m_cur = 0; m_ramp = 0; m_busy = 1'b0;
    bus.ctrl_run_in = 1'b0;
    #1 reset_checks("async_reset");
    tick();
    tick();
    rst = 1'b0;
  endtask

  // stimulus
  initial begin
    int la, lv, sa, ra, ba, act;
    bus.ctrl_run_in    = 1'b0;
    bus.ctrl_brake_in  = 1'b0;
    bus.duty_target_in = '0;
    bus.duty_load_in   = 1'b0;
    #2 reset_checks("por");
    tick();
    rst = 1'b0;

    idle_cycles(2, 5);
    start_run();
    repeat (3) do_period(-1, -1, -1, -1, -1);
    do_period(3, 0, -1, -1, -1);
    repeat (2) do_period(-1, -1, -1, -1, -1);
    do_period(3, DMAX, -1, -1, -1);
    repeat (2) do_period(-1, -1, -1, -1, -1);
    do_period(0, 5, -1, -1, -1);
    do_period(3, 12, -1, -1, -1);
    do_period(-1, -1, -1, -1, -1);
    do_period(-1, -1, 8, -1, -1);
    idle_cycles(3, 7);
    start_run();
    repeat (10) do_period(-1, -1, -1, -1, -1);
    do_period(-1, -1, -1, -1, 2);
    idle_cycles(2, 12);
    start_run();
    reset_mid(9);
    idle_cycles(4, -1);
    idle_cycles(1, 9);
    start_run();
    do_period(-1, -1, 4, 10, -1);
    do_period(-1, -1, 6, 15, -1);

    for (int p = 0; p < 180; p++) begin
      la = -1; sa = -1; ra = -1; ba = -1;
      if ($urandom_range(0, 1) == 1) la = int'($urandom_range(0, PERIOD - 1));
      act = int'($urandom_range(0, 7));
      if (act == 0) lv = 0;
      else if (act == 1) lv = DMAX;
      else lv = int'($urandom_range(0, DMAX));
      act = int'($urandom_range(0, 19));
      if (act < 2) begin
        sa = int'($urandom_range(0, PERIOD - 1));
        if (act == 0 && sa < PERIOD - 1) ra = int'($urandom_range(sa + 1, PERIOD - 1));
      end else if (act == 2) begin
        ba = int'($urandom_range(0, PERIOD - 1));
      end
      do_period(la, lv, sa, ra, ba);
      if (!m_busy) begin
        if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)), int'($urandom_range(0, DMAX)));
        else idle_cycles(int'($urandom_range(1, 3)), -1);
        start_run();
      end
    end

    do_period(-1, -1, 0, -1, -1);
    idle_cycles(3, -1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sc_pwm_ramp_controller.md
Name: sc_pwm_ramp_controller

Overview:
- Sequencing controller for one SC_COUNTER_PWM instance (one motor channel).
- Drives the counter's enable, clear and compare inputs and consumes its end-of-count and compare flags.
- Produces a glitch-free PWM output. Duty changes take effect only at period boundaries; optional soft-start ramping.
- Sits between the motion/command logic and the counter.

Parameters:
- N, 8, counter width; PWM period = 2^N clocks; duty range 0..2^N-1.
- RAMP_STEP, 1, duty increment/decrement per ramp tick (1..2^N-1).
- RAMP_DIV, 4, PWM periods per ramp tick (1..255).

Ports:
- SC_COUNTER_PWM_CLOCK  in  1  system clock.
- SC_COUNTER_PWM_RESET_InHigh  in  1  reset, asynchronous, active-high.
- ctrl_run_in  in  1  level; 1 = run channel, 0 = graceful stop at end of period.
- ctrl_brake_in  in  1  level; 1 = immediate stop, priority over everything except reset.
- duty_target_in  in  N  requested duty, in clocks high per period.
- duty_load_in  in  1  one-cycle strobe; captures duty_target_in into duty_tgt.
- cnt_endcount_outlow_in  in  1  from counter; 0 when count == 2^N-1.
- cnt_flag_outlow_in  in  1  from counter; 0 when count == compare bus.
- cnt_enable_inlow_out  out  1  to counter enable (0 = count).
- cnt_clear_inlow_out  out  1  to counter clear (0 = clear).
- cnt_flagcomp_out  out  N  to counter compare bus.
- pwm_out  out  1  registered PWM output.
- period_done_out  out  1  one-cycle pulse on the clock after each completed period in RUN/STOPPING.
- at_target_out  out  1  1 when duty_cur == duty_tgt.
- busy_out  out  1  1 when state != IDLE.

Behaviour:
- Registers: state, duty_tgt[N], duty_cur[N], pwm_reg, ramp_cnt[8], period_done.
- Reset values: state=IDLE, duty_tgt=0, duty_cur=0, pwm_reg=0, ramp_cnt=0, period_done=0.
- Outputs at reset: pwm_out=0, cnt_clear_inlow_out=0, cnt_enable_inlow_out=1, cnt_flagcomp_out=0, busy_out=0, at_target_out=1.
- duty_load_in captures in any state, one cycle latency. It never changes duty_cur directly.
- "Wrap edge" = the clock edge where cnt_endcount_outlow_in==0.
- Compare: cnt_flagcomp_out = duty_cur-1 when duty_cur≥1, else 0 (unused when duty 0).
- PWM: pwm_reg set at the wrap edge (and on the IDLE->RUN edge) if the duty_cur value for the new period is ≠0. pwm_reg cleared at the edge where cnt_flag_outlow_in==0. Result: exactly duty_cur high clocks per period, starting at count 0. When set and clear coincide, set wins.
- duty_cur updates only at a wrap edge or on IDLE->RUN, so a period is never mid-changed.
- IDLE: clear_inlow=0, enable_inlow=1, pwm=0.
  - IDLE->RUN when ctrl_run_in=1 and ctrl_brake_in=0.
  - Clear and enable released the cycle after the transition; counter shows 0 for the first RUN cycle.
- RUN: clear_inlow=1, enable_inlow=0.
  - ctrl_run_in=0 -> STOPPING.
  - At each wrap edge: period_done pulses; duty_cur updated per ramp rule.
- STOPPING: counting continues. At the next wrap edge -> IDLE, pwm_reg=0, duty_cur unchanged (no new period starts). ctrl_run_in returning to 1 in STOPPING -> RUN, with no break in the period.
- Brake: ctrl_brake_in=1 in any state -> IDLE at next edge; pwm_reg=0, ramp_cnt=0, duty_cur=0 (ramp build only), no period_done pulse.
- Reset mid-period: all registers return to reset values asynchronously; the counter resets on the same signal.
- at_target_out and busy_out are combinational from registers.

Optional Feature:
- Macro SC_PWM_RAMP_EN.
- Defined:
  - On IDLE->RUN, duty_cur=0 (soft start).
  - At each wrap edge ramp_cnt increments. When it reaches RAMP_DIV-1 it resets to 0 and duty_cur moves toward duty_tgt by RAMP_STEP, saturating at duty_tgt with no overshoot. Arithmetic is N+1 bits, with no wrap past 0 or 2^N-1.
  - Entering IDLE from STOPPING keeps duty_cur.
- Not defined:
  - duty_cur := duty_tgt at every wrap edge and on IDLE->RUN.
  - ramp_cnt and the RAMP_* parameters are unused.

Test Plan (N=4, RAMP_STEP=2, RAMP_DIV=2):
1. Reset, then run=1, load 5, no ramp: from the first RUN cycle, pwm_out is high 5 clocks and low 11, repeating every 16; period_done pulses each wrap.
2. Duty edges: target 0 -> pwm_out constantly 0. Target 15 -> high 15, low 1 per period.
3. Mid-period change: load 12 at count 3 while duty is 5. The current period still gives 5 high; the next gives 12.
4. Ramp build: load 7 then run. Duty per period is 0,0,2,2,4,4,6,6,7,7. at_target_out rises with the first duty-7 period.
5. Stop vs brake:
   - run=0 at count 8 -> pwm completes the period; busy_out falls after the wrap edge; counter held at 0.
   - brake=1 at count 2 with pwm high -> pwm_out=0 and cnt_clear_inlow_out=0 on the next edge.
6. Async reset asserted at count 9 with pwm high -> all outputs at reset values immediately; after release, state is IDLE until run.
